// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decoder front end: sizes, symbol types
// and the observation feeder state encoding.
package viterbi_pkg;

   localparam int SYM_W   = 2;
   localparam int K       = 3;
   localparam int LEN_W   = 3;
   localparam int MAX_LEN = 7;

   typedef logic [SYM_W-1:0] sym_t;
   typedef logic [LEN_W-1:0] len_t;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      ISSUE  = 2'd1,
      STREAM = 2'd2,
      WAIT   = 2'd3
   } feed_state_e;

   localparam sym_t SYM_K    = sym_t'(K);
   localparam len_t LAST_IDX = len_t'(MAX_LEN - 1);

   // Symbols at or above the alphabet size are outside the decoder's model.
   function automatic logic sym_illegal(sym_t s);
      return s >= SYM_K;
   endfunction

endpackage

// File: rtl/viterbi_obs_feeder_if.sv
// Upstream symbol stream plus decoder launch/observation signals of the feeder.
interface viterbi_obs_feeder_if;
   import viterbi_pkg::*;

   logic in_valid;
   logic in_ready;
   sym_t in_obs;
   logic in_last;
   logic start;
   len_t length;
   sym_t obs_in;
   logic obs_valid;
   logic dec_done;
   logic busy;
   logic err_sym;

   modport master (
      output in_valid, in_obs, in_last, dec_done,
      input  in_ready, start, length, obs_in, obs_valid, busy, err_sym
   );

   modport slave (
      input  in_valid, in_obs, in_last, dec_done,
      output in_ready, start, length, obs_in, obs_valid, busy, err_sym
   );

endinterface

// File: rtl/viterbi_obs_buf.sv
// MAX_LEN x SYM_W symbol register file: one synchronous write port and one
// combinational read port.
module viterbi_obs_buf
   import viterbi_pkg::*;
(
   input  logic clk,
   input  logic we,
   input  len_t waddr,
   input  sym_t wdata,
   input  len_t raddr,
   output sym_t rdata
);

   sym_t mem [MAX_LEN];

   // NOTE: storage has no reset; every entry is written before it is read,
   // and leaving it out keeps the array mappable to plain flops/LUT-RAM.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/viterbi_obs_feeder.sv
// Buffers one observation sequence, launches the decoder with start/length and
// the first symbol, streams the rest, then holds start until a done edge.
module viterbi_obs_feeder
   import viterbi_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   viterbi_obs_feeder_if.slave  bus
);

   feed_state_e state, state_d;
   len_t        count, count_d;
   len_t        k, k_d;
   len_t        length_q, length_d;
   sym_t        obs_q, obs_d;
   logic        obs_valid_q, obs_valid_d;
   logic        start_q, start_d;
   logic        err_q, err_d;
   logic        done_q;

   logic        wr_en;
   len_t        raddr;
   sym_t        rdata;

   assign bus.in_ready = (state == FILL);
   assign wr_en        = bus.in_valid && (state == FILL);

   viterbi_obs_buf u_buf (
      .clk   (clk),
      .we    (wr_en),
      .waddr (count),
      .wdata (bus.in_obs),
      .raddr (raddr),
      .rdata (rdata)
   );

   // NOTE: every variable gets its hold value first so no path infers a latch.
   always_comb begin
      state_d     = state;
      count_d     = count;
      k_d         = k;
      length_d    = length_q;
      obs_d       = obs_q;
      obs_valid_d = obs_valid_q;
      start_d     = start_q;
      err_d       = err_q;
      raddr       = '0;

      unique case (state)
         FILL: begin
            if (bus.in_valid) begin
               count_d = count + len_t'(1);
               if (sym_illegal(bus.in_obs)) err_d = 1'b1;
               if (bus.in_last || count == LAST_IDX) begin
                  length_d = count + len_t'(1);
                  start_d  = 1'b1;
                  // buf[0] is being written this cycle when count is zero
                  obs_d    = (count == '0) ? bus.in_obs : rdata;
                  k_d      = len_t'(1);
                  state_d  = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (length_q == len_t'(1)) begin
               obs_valid_d = 1'b0;
               state_d     = WAIT;
            end else begin
               raddr       = len_t'(1);
               obs_d       = rdata;
               obs_valid_d = 1'b1;
               k_d         = len_t'(2);
               state_d     = STREAM;
            end
         end
         STREAM: begin
            // k indexes the next symbol to load; k==length means buf[length-1] is on the bus
            if (k == length_q) begin
               obs_valid_d = 1'b0;
               state_d     = WAIT;
            end else begin
               raddr = k;
               obs_d = rdata;
               k_d   = k + len_t'(1);
            end
         end
         WAIT: begin
            if (bus.dec_done && !done_q) begin
               start_d = 1'b0;
               count_d = '0;
               err_d   = 1'b0;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update
   // from the same pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FILL;
         count       <= '0;
         k           <= '0;
         length_q    <= '0;
         obs_q       <= '0;
         obs_valid_q <= 1'b0;
         start_q     <= 1'b0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state       <= state_d;
         count       <= count_d;
         k           <= k_d;
         length_q    <= length_d;
         obs_q       <= obs_d;
         obs_valid_q <= obs_valid_d;
         start_q     <= start_d;
         err_q       <= err_d;
         done_q      <= bus.dec_done;
      end
   end

   assign bus.start     = start_q;
   assign bus.length    = length_q;
   assign bus.obs_in    = obs_q;
   assign bus.obs_valid = obs_valid_q;
   assign bus.err_sym   = err_q;
   assign bus.busy      = (state != FILL);

endmodule

// File: tb/tb_viterbi_obs_feeder.sv
// Directed and randomized checks of the observation feeder against a
// sequence-level model built from a queue of upstream beats.
module tb_viterbi_obs_feeder;
   import viterbi_pkg::*;

   typedef struct {
      sym_t sym;
      bit   last;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   viterbi_obs_feeder_if bus ();

   viterbi_obs_feeder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   beat_t beat_q[$];
   int    tests = 0;
   int    fails = 0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beat(input int sym, input bit last);
      beat_t b;
      b.sym  = sym_t'(sym);
      b.last = last;
      beat_q.push_back(b);
   endtask

   task automatic top_up();
      while (beat_q.size() < MAX_LEN)
         push_beat($urandom_range(0, 3), ($urandom_range(0, 3) == 0));
   endtask

   // Sequence length implied by the pending beats: up to the first last, capped at MAX_LEN.
   function automatic int model_len();
      int n = 0;
      while (n < beat_q.size()) begin
         n++;
         if (beat_q[n-1].last || n == MAX_LEN) break;
      end
      return n;
   endfunction

   task automatic run_seq(input string tag, input bit stale_done);
      int   n;
      sym_t exp_q[$];
      bit   exp_err;
      n       = model_len();
      exp_err = 1'b0;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(beat_q[i].sym);
         if (int'(beat_q[i].sym) >= K) exp_err = 1'b1;
      end

      for (int i = 0; i < n; i++) begin
         check($sformatf("%s.ready%0d", tag, i), bus.in_ready, 1);
         bus.in_valid = 1'b1;
         bus.in_obs   = beat_q[0].sym;
         bus.in_last  = beat_q[0].last;
         void'(beat_q.pop_front());
         tick();
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;

      check({tag, ".issue_ready"}, bus.in_ready, 0);
      check({tag, ".issue_start"}, bus.start, 1);
      check({tag, ".issue_busy"}, bus.busy, 1);
      check({tag, ".issue_len"}, bus.length, n);
      check({tag, ".issue_obs"}, bus.obs_in, exp_q[0]);
      check({tag, ".issue_valid"}, bus.obs_valid, 0);
      check({tag, ".issue_err"}, bus.err_sym, exp_err);

      if (stale_done) bus.dec_done = 1'b1;
      for (int i = 1; i < n; i++) begin
         tick();
         check($sformatf("%s.valid%0d", tag, i), bus.obs_valid, 1);
         check($sformatf("%s.obs%0d", tag, i), bus.obs_in, exp_q[i]);
      end
      tick();
      check({tag, ".wait_valid"}, bus.obs_valid, 0);
      check({tag, ".wait_start"}, bus.start, 1);
      check({tag, ".wait_busy"}, bus.busy, 1);
      check({tag, ".wait_err"}, bus.err_sym, exp_err);

      if (stale_done) begin
         repeat (3) tick();
         check({tag, ".stale_hold"}, bus.start, 1);
         bus.dec_done = 1'b0;
         tick();
         check({tag, ".low_hold"}, bus.start, 1);
      end
      bus.dec_done = 1'b1;
      tick();
      check({tag, ".done_start"}, bus.start, 0);
      check({tag, ".done_ready"}, bus.in_ready, 1);
      check({tag, ".done_busy"}, bus.busy, 0);
      check({tag, ".done_err"}, bus.err_sym, 0);
      bus.dec_done = 1'b0;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_obs   = '0;
      bus.in_last  = 1'b0;
      bus.dec_done = 1'b0;
      rst          = 1'b1;
      repeat (2) tick();

      check("rst.start", bus.start, 0);
      check("rst.length", bus.length, 0);
      check("rst.obs_in", bus.obs_in, 0);
      check("rst.obs_valid", bus.obs_valid, 0);
      check("rst.busy", bus.busy, 0);
      check("rst.err", bus.err_sym, 0);
      rst = 1'b0;
      check("rst.ready", bus.in_ready, 1);

      // 0,1,2,1 closed by in_last
      push_beat(0, 0); push_beat(1, 0); push_beat(2, 0); push_beat(1, 1);
      run_seq("four", 1'b0);

      // single symbol
      push_beat(2, 1);
      run_seq("single", 1'b0);

      // 9 beats without in_last: truncate at MAX_LEN, the rest starts the next sequence
      for (int i = 0; i < 9; i++) push_beat(i % 3, 0);
      run_seq("trunc", 1'b0);
      check("trunc.leftover", beat_q.size(), 2);
      top_up();
      run_seq("trunc_next", 1'b0);

      // illegal symbol in the middle
      push_beat(1, 0); push_beat(3, 0); push_beat(0, 1);
      run_seq("illegal", 1'b0);

      // stale done level entering WAIT
      push_beat(2, 0); push_beat(0, 0); push_beat(1, 1);
      run_seq("stale", 1'b1);
      push_beat(1, 1);
      run_seq("stale_len1", 1'b1);

      // reset during STREAM
      beat_q.delete();
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_obs   = sym_t'(i % 3);
         bus.in_last  = (i == 3);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      tick();
      check("abort.streaming", bus.obs_valid, 1);
      rst = 1'b1;
      #1;
      check("abort.obs_valid", bus.obs_valid, 0);
      check("abort.start", bus.start, 0);
      check("abort.busy", bus.busy, 0);
      check("abort.err", bus.err_sym, 0);
      tick();
      rst = 1'b0;
      check("abort.ready", bus.in_ready, 1);
      push_beat(2, 0); push_beat(1, 1);
      run_seq("after_abort", 1'b0);

      // randomized sequences drawn from a continuous beat stream
      for (int s = 0; s < 25; s++) begin
         top_up();
         run_seq($sformatf("rnd%0d", s), ($urandom_range(0, 4) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
